reg_bank_arbiter: RTL and testbench

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

---
 rtl/reg_arb_pkg.sv | 23 ++
 rtl/reg_bank_arbiter_rr_picker.sv | 29 ++
 rtl/reg_bank_arbiter.sv | 128 ++++++++++++
 tb/tb_reg_bank_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: FSM state encoding and an elaboration-time log2 helper
// shared by reg_bank_arbiter and rr_picker.
package reg_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Ceiling log2, never below 1 so single-entry widths stay legal.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >>> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector; returns the first set request
// found searching upward from i_last+1 with wrap-around, as a one-hot vector.
module rr_picker
  import reg_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int LW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [LW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_winner
);

  always_comb begin
    logic          found;
    logic [LW-1:0] idx;
    o_winner = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = LW'((int'(i_last) + k) % NUM_REQ);
      if (!found && i_req[idx]) begin
        o_winner[idx] = 1'b1;
        found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbitrated register bank with registered read port.
// Define ARB_HOLD_LIMIT_EN to force release of a grant after MAX_HOLD cycles.
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 8,
  parameter  int MAX_HOLD = 4,
  localparam int AW       = clog2(DEPTH),
  localparam int LW       = clog2(NUM_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_we,
  input  logic [NUM_REQ*AW-1:0]     i_waddr,
  input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic                      o_ack,
  input  logic [AW-1:0]             i_raddr,
  output logic [DATA_W-1:0]         o_rdata
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DEPTH != (1 << AW) || MAX_HOLD < 1) begin : g_param_check
    $error("reg_bank_arbiter: unsupported parameter set");
  end

  arb_state_t          r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [LW-1:0]       r_last;
  logic                r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic [DATA_W-1:0]   r_bank [DEPTH];

  logic [NUM_REQ-1:0]  w_winner;
  logic [LW-1:0]       w_winner_idx;
  logic                w_wr_en;
  logic [AW-1:0]       w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int HW = clog2(MAX_HOLD + 1);
  logic [HW-1:0]       r_hold;
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .i_req    (i_req),
    .i_last   (r_last),
    .o_winner (w_winner)
  );

  always_comb begin
    w_winner_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner[i]) w_winner_idx = LW'(i);
    end
  end

  // r_last always names the granted requester while in GRANT, so it selects the write slice.
  assign w_wr_en   = |(r_gnt & i_we);
  assign w_wr_addr = i_waddr[int'(r_last)*AW +: AW];
  assign w_wr_data = i_wdata[int'(r_last)*DATA_W +: DATA_W];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_last  <= LW'(NUM_REQ - 1);
`ifdef ARB_HOLD_LIMIT_EN
      r_hold  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            r_state <= GRANT;
            r_gnt   <= w_winner;
            r_last  <= w_winner_idx;
`ifdef ARB_HOLD_LIMIT_EN
            r_hold  <= HW'(1);
`endif
          end
        end
        GRANT: begin
          // Every release goes back through IDLE, guaranteeing a GNT=0 cycle.
          if (!(|(r_gnt & i_req))) begin
            r_state <= IDLE;
            r_gnt   <= '0;
`ifdef ARB_HOLD_LIMIT_EN
            r_hold  <= '0;
          end else if (r_hold == HW'(MAX_HOLD)) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_hold  <= '0;
          end else begin
            r_hold  <= r_hold + HW'(1);
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  // Read samples the bank before this edge's write lands, giving read-before-write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_wr_en;
      r_rdata <= r_bank[i_raddr];
      if (w_wr_en) r_bank[w_wr_addr] <= w_wr_data;
    end
  end

  assign o_gnt   = r_gnt;
  assign o_ack   = r_ack;
  assign o_rdata = r_rdata;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed self-checking bench for reg_bank_arbiter
// (default parameters; hold-limit scenario follows ARB_HOLD_LIMIT_EN).
module tb_reg_bank_arbiter;

  logic        clk;
  logic        rstN;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        ack;
  logic [2:0]  raddr;
  logic [7:0]  rdata;

  int nChecks = 0;
  int nFails  = 0;

  reg_bank_arbiter #(
    .NUM_REQ  (4),
    .DATA_W   (8),
    .DEPTH    (8),
    .MAX_HOLD (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rstN),
    .i_req   (req),
    .i_we    (we),
    .i_waddr (waddr),
    .i_wdata (wdata),
    .o_gnt   (gnt),
    .o_ack   (ack),
    .i_raddr (raddr),
    .o_rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setSlot(input int idx, input logic [2:0] addr, input logic [7:0] data);
    waddr[idx*3 +: 3] = addr;
    wdata[idx*8 +: 8] = data;
  endtask

  task automatic test_reset();
    rstN = 1'b0; req = '0; we = '0; waddr = '0; wdata = '0; raddr = 3'd3;
    #1;
    nChecks++;
    if (gnt !== 4'b0000) begin nFails++; $display("[TB] FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
    tick();
    tick();
    nChecks++;
    if (ack !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ack: got %b expected %b", ack, 1'b0); end
    nChecks++;
    if (rdata !== 8'h00) begin nFails++; $display("[TB] FAIL reset_rdata: got %h expected %h", rdata, 8'h00); end
    rstN = 1'b1;
  endtask

  task automatic test_basic_write();
    req = 4'b0001; we = 4'b0001; setSlot(0, 3'd3, 8'hA5); raddr = 3'd3;
    tick();
    nChecks++;
    if (gnt !== 4'b0001) begin nFails++; $display("[TB] FAIL basic_gnt: got %b expected %b", gnt, 4'b0001); end
    nChecks++;
    if (ack !== 1'b0) begin nFails++; $display("[TB] FAIL basic_ack_early: got %b expected %b", ack, 1'b0); end
    tick();
    nChecks++;
    if (ack !== 1'b1) begin nFails++; $display("[TB] FAIL basic_ack: got %b expected %b", ack, 1'b1); end
    nChecks++;
    if (rdata !== 8'h00) begin nFails++; $display("[TB] FAIL basic_rdata_old: got %h expected %h", rdata, 8'h00); end
    req = '0; we = '0;
    tick();
    nChecks++;
    if (ack !== 1'b0) begin nFails++; $display("[TB] FAIL basic_ack_pulse: got %b expected %b", ack, 1'b0); end
    nChecks++;
    if (rdata !== 8'hA5) begin nFails++; $display("[TB] FAIL basic_rdata: got %h expected %h", rdata, 8'hA5); end
    nChecks++;
    if (gnt !== 4'b0000) begin nFails++; $display("[TB] FAIL basic_release: got %b expected %b", gnt, 4'b0000); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] expGnt;
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    for (int i = 0; i < 4; i++) setSlot(i, 3'(i + 4), 8'(8'h10 + i));
    req = 4'b1111; we = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      expGnt = 4'b0001 << order[s];
      tick();
      nChecks++;
      if (gnt !== expGnt) begin nFails++; $display("[TB] FAIL rr_gnt step %0d: got %b expected %b", s, gnt, expGnt); end
      req[order[s]] = 1'b0;
      tick();
      nChecks++;
      if (gnt !== 4'b0000) begin nFails++; $display("[TB] FAIL rr_idle step %0d: got %b expected %b", s, gnt, 4'b0000); end
      nChecks++;
      if (ack !== 1'b1) begin nFails++; $display("[TB] FAIL rr_ack step %0d: got %b expected %b", s, ack, 1'b1); end
      req[order[s]] = 1'b1;
    end
    req = '0; we = '0; raddr = 3'd6;
    tick();
    nChecks++;
    if (rdata !== 8'h12) begin nFails++; $display("[TB] FAIL rr_bank6: got %h expected %h", rdata, 8'h12); end
    raddr = 3'd7;
    tick();
    nChecks++;
    if (rdata !== 8'h13) begin nFails++; $display("[TB] FAIL rr_bank7: got %h expected %h", rdata, 8'h13); end
  endtask

  task automatic test_ignore_nongranted();
    for (int i = 0; i < 4; i++) setSlot(i, 3'd2, 8'hEE);
    req = 4'b0100; we = 4'b1011;
    tick();
    nChecks++;
    if (gnt !== 4'b0100) begin nFails++; $display("[TB] FAIL ign_gnt: got %b expected %b", gnt, 4'b0100); end
    tick();
    nChecks++;
    if (ack !== 1'b0) begin nFails++; $display("[TB] FAIL ign_ack: got %b expected %b", ack, 1'b0); end
    req = '0; we = '0; raddr = 3'd2;
    tick();
    nChecks++;
    if (ack !== 1'b0) begin nFails++; $display("[TB] FAIL ign_ack2: got %b expected %b", ack, 1'b0); end
    nChecks++;
    if (rdata !== 8'h00) begin nFails++; $display("[TB] FAIL ign_bank2: got %h expected %h", rdata, 8'h00); end
  endtask

  task automatic test_reset_mid_write();
    req = 4'b0001; we = 4'b0001; setSlot(0, 3'd5, 8'h3C);
    tick();
    nChecks++;
    if (gnt !== 4'b0001) begin nFails++; $display("[TB] FAIL rst_pre_gnt: got %b expected %b", gnt, 4'b0001); end
    rstN = 1'b0;
    #1;
    nChecks++;
    if (gnt !== 4'b0000) begin nFails++; $display("[TB] FAIL rst_async_gnt: got %b expected %b", gnt, 4'b0000); end
    tick();
    rstN = 1'b1; req = '0; we = '0; raddr = 3'd5;
    tick();
    nChecks++;
    if (rdata !== 8'h00) begin nFails++; $display("[TB] FAIL rst_bank5: got %h expected %h", rdata, 8'h00); end
    nChecks++;
    if (ack !== 1'b0) begin nFails++; $display("[TB] FAIL rst_ack: got %b expected %b", ack, 1'b0); end
    req = 4'b1001;
    tick();
    nChecks++;
    if (gnt !== 4'b0001) begin nFails++; $display("[TB] FAIL rst_first_winner: got %b expected %b", gnt, 4'b0001); end
    req = '0;
    tick();
  endtask

  task automatic test_read_before_write();
    req = 4'b0010; we = 4'b0010; setSlot(1, 3'd1, 8'h11); raddr = 3'd1;
    tick();
    nChecks++;
    if (gnt !== 4'b0010) begin nFails++; $display("[TB] FAIL rbw_gnt: got %b expected %b", gnt, 4'b0010); end
    tick();
    nChecks++;
    if (rdata !== 8'h00) begin nFails++; $display("[TB] FAIL rbw_first: got %h expected %h", rdata, 8'h00); end
    nChecks++;
    if (ack !== 1'b1) begin nFails++; $display("[TB] FAIL rbw_ack: got %b expected %b", ack, 1'b1); end
    setSlot(1, 3'd1, 8'h22);
    tick();
    nChecks++;
    if (rdata !== 8'h11) begin nFails++; $display("[TB] FAIL rbw_second: got %h expected %h", rdata, 8'h11); end
    req = '0; we = '0;
    tick();
    nChecks++;
    if (rdata !== 8'h22) begin nFails++; $display("[TB] FAIL rbw_third: got %h expected %h", rdata, 8'h22); end
    nChecks++;
    if (ack !== 1'b0) begin nFails++; $display("[TB] FAIL rbw_ack_end: got %b expected %b", ack, 1'b0); end
  endtask

`ifdef ARB_HOLD_LIMIT_EN
  task automatic test_hold();
    logic [3:0] expGnt;
    req = 4'b0011;
    for (int p = 0; p < 2; p++) begin
      expGnt = 4'b0001 << p;
      for (int c = 0; c < 4; c++) begin
        tick();
        nChecks++;
        if (gnt !== expGnt) begin nFails++; $display("[TB] FAIL hold_gnt p%0d c%0d: got %b expected %b", p, c, gnt, expGnt); end
      end
      tick();
      nChecks++;
      if (gnt !== 4'b0000) begin nFails++; $display("[TB] FAIL hold_release p%0d: got %b expected %b", p, gnt, 4'b0000); end
    end
    req = '0;
    tick();
  endtask
`else
  task automatic test_hold();
    req = 4'b0001;
    for (int c = 0; c < 7; c++) begin
      tick();
      nChecks++;
      if (gnt !== 4'b0001) begin nFails++; $display("[TB] FAIL hold_persist c%0d: got %b expected %b", c, gnt, 4'b0001); end
    end
    req = '0;
    tick();
    nChecks++;
    if (gnt !== 4'b0000) begin nFails++; $display("[TB] FAIL hold_drop: got %b expected %b", gnt, 4'b0000); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_write();
    test_round_robin();
    test_ignore_nongranted();
    test_reset_mid_write();
    test_read_before_write();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
